// File: rtl/ram_arbiter_if.sv
// Requester A/B and block-RAM signal bundle for ram_arbiter.
// slave = arbiter view; master = requesters plus RAM view.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    // A request is held until its gnt; gnt in the same cycle means the operation was accepted.
    // A read's rvalid/rdata follow exactly one cycle after its grant.
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_lock;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_lock,
        output b_gnt, b_rvalid, b_rdata,
        output mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_lock,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter for a shared block RAM, with B bus lock and a
// PLL-stable startup hold before any memory traffic.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int STARTUP_CYCLES = 41,
    parameter int CNT_WIDTH      = 9
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         pll_lock,
    output logic         ready,
    ram_arbiter_if.slave bus
);
    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_b_q, last_b_d;
    logic                 lock_q, lock_d;
    logic                 rd_pend_q, rd_pend_d;
    logic                 rd_owner_q, rd_owner_d;

    logic                  run;
    logic                  lock_eff;
    logic                  a_gnt, b_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (!pll_lock) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_WIDTH'(STARTUP_CYCLES)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!pll_lock) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Dropping b_lock releases A in the same cycle; the register only clears on the edge.
    assign run      = (state_q == RUN);
    assign lock_eff = lock_q & bus.b_lock;

    always_comb begin
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        last_b_d   = last_b_q;
        lock_d     = lock_q;
        rd_pend_d  = 1'b0;
        rd_owner_d = rd_owner_q;
        if (run) begin
            a_gnt = bus.a_req & ~lock_eff & (~bus.b_req | last_b_q);
            b_gnt = bus.b_req & (lock_eff | ~bus.a_req | ~last_b_q);
        end
        if (a_gnt) begin
            last_b_d = 1'b0;
        end else if (b_gnt) begin
            last_b_d = 1'b1;
        end
        if (!bus.b_lock) begin
            lock_d = 1'b0;
        end else if (b_gnt) begin
            lock_d = 1'b1;
        end
        sel_we    = b_gnt ? bus.b_we    : bus.a_we;
        sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
        sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
        if ((a_gnt | b_gnt) & ~sel_we) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = b_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetq) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            last_b_q   <= 1'b1;
            lock_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_b_q   <= last_b_d;
            lock_q     <= lock_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign ready = run;
    assign rdata = bus.mem_read_data;

    always_comb begin
        bus.a_gnt            = a_gnt;
        bus.b_gnt            = b_gnt;
        bus.mem_write_enable = (a_gnt | b_gnt) & sel_we;
        bus.mem_read_enable  = (a_gnt | b_gnt) & ~sel_we;
        bus.mem_write_addr   = sel_addr;
        bus.mem_read_addr    = sel_addr;
        bus.mem_write_data   = sel_wdata;
        bus.a_rvalid         = rd_pend_q & ~rd_owner_q;
        bus.b_rvalid         = rd_pend_q & rd_owner_q;
        bus.a_rdata          = (rd_pend_q & ~rd_owner_q) ? rdata : '0;
        bus.b_rdata          = (rd_pend_q & rd_owner_q) ? rdata : '0;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: startup hold, reads/writes, round-robin,
// B lock, PLL drop, reset mid-read and address wrap against a 4096x16 RAM model.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic resetq;
    logic pll_lock;
    logic ready;
    int   errors = 0;
    int   checks = 0;

    ram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    ram_arbiter #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .STARTUP_CYCLES(41), .CNT_WIDTH(9)
    ) dut (
        .clk(clk), .resetq(resetq), .pll_lock(pll_lock), .ready(ready), .bus(bus)
    );

    always #5 clk = ~clk;

    // Registered-read block RAM; addresses wrap modulo 4096.
    logic [15:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_write_addr[11:0]] <= bus.mem_write_data;
        if (bus.mem_read_enable)  bus.mem_read_data <= mem[bus.mem_read_addr[11:0]];
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    initial begin
        resetq = 1'b0;
        pll_lock = 1'b0;
        bus.b_lock = 1'b0;
        set_a(0, 0, 16'h0, 16'h0);
        set_b(0, 0, 16'h0, 16'h0);
        @(negedge clk);
        tick; tick;

        // Reset state with A requesting
        set_a(1, 0, 16'h0000, 16'h0);
        #1;
        check("rst_ready", ready, 0);
        check("rst_a_gnt", bus.a_gnt, 0);
        check("rst_mem_re", bus.mem_read_enable, 0);
        check("rst_a_rvalid", bus.a_rvalid, 0);
        check("rst_b_rvalid", bus.b_rvalid, 0);

        // Startup with a pll_lock drop at cycle 20
        resetq = 1'b1;
        pll_lock = 1'b1;
        repeat (20) tick;
        pll_lock = 1'b0;
        tick;
        pll_lock = 1'b1;
        repeat (40) tick;
        #1 check("startup_restart_40", ready, 0);
        tick;
        #1 check("startup_41_ready", ready, 0);
        check("startup_41_gnt", bus.a_gnt, 0);
        tick;
        #1 check("startup_ready", ready, 1);
        check("startup_a_gnt", bus.a_gnt, 1);
        check("startup_mem_re", bus.mem_read_enable, 1);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        #1 check("startup_a_rvalid", bus.a_rvalid, 1);
        check("startup_b_rvalid", bus.b_rvalid, 0);

        // Single write then read
        set_a(1, 1, 16'h0010, 16'h1234);
        #1 check("wr_a_gnt", bus.a_gnt, 1);
        check("wr_mem_we", bus.mem_write_enable, 1);
        check("wr_mem_re", bus.mem_read_enable, 0);
        check("wr_waddr", bus.mem_write_addr, 16'h0010);
        check("wr_wdata", bus.mem_write_data, 16'h1234);
        tick;
        set_a(1, 0, 16'h0010, 16'h0);
        #1 check("rd_a_gnt", bus.a_gnt, 1);
        check("rd_mem_re", bus.mem_read_enable, 1);
        check("rd_raddr", bus.mem_read_addr, 16'h0010);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        #1 check("rd_a_rvalid", bus.a_rvalid, 1);
        check("rd_a_rdata", bus.a_rdata, 16'h1234);
        check("rd_b_rvalid", bus.b_rvalid, 0);
        check("rd_b_rdata", bus.b_rdata, 16'h0);
        tick;
        #1 check("rd_a_rvalid_once", bus.a_rvalid, 0);

        // Preload: A writes two words, then B writes two words (B granted last)
        set_a(1, 1, 16'h0020, 16'hAAAA); tick;
        set_a(1, 1, 16'h0021, 16'hAAAB); tick;
        set_a(0, 0, 16'h0, 16'h0);
        set_b(1, 1, 16'h0030, 16'hBBBB);
        #1 check("pre_b_gnt", bus.b_gnt, 1);
        check("pre_b_waddr", bus.mem_write_addr, 16'h0030);
        tick;
        set_b(1, 1, 16'h0031, 16'hBBBC); tick;

        // Contention: both requesting for four cycles -> A,B,A,B
        set_a(1, 0, 16'h0020, 16'h0);
        set_b(1, 0, 16'h0030, 16'h0);
        #1 check("rr0_a_gnt", bus.a_gnt, 1);
        check("rr0_b_gnt", bus.b_gnt, 0);
        check("rr0_raddr", bus.mem_read_addr, 16'h0020);
        tick;
        set_a(1, 0, 16'h0021, 16'h0);
        #1 check("rr1_a_gnt", bus.a_gnt, 0);
        check("rr1_b_gnt", bus.b_gnt, 1);
        check("rr1_raddr", bus.mem_read_addr, 16'h0030);
        check("rr1_a_rdata", bus.a_rdata, 16'hAAAA);
        check("rr1_b_rvalid", bus.b_rvalid, 0);
        tick;
        set_b(1, 0, 16'h0031, 16'h0);
        #1 check("rr2_a_gnt", bus.a_gnt, 1);
        check("rr2_b_gnt", bus.b_gnt, 0);
        check("rr2_b_rvalid", bus.b_rvalid, 1);
        check("rr2_b_rdata", bus.b_rdata, 16'hBBBB);
        check("rr2_a_rdata", bus.a_rdata, 16'h0);
        tick;
        set_a(1, 0, 16'h0022, 16'h0);
        #1 check("rr3_b_gnt", bus.b_gnt, 1);
        check("rr3_a_gnt", bus.a_gnt, 0);
        check("rr3_a_rdata", bus.a_rdata, 16'hAAAB);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        set_b(0, 0, 16'h0, 16'h0);
        #1 check("rr4_b_rdata", bus.b_rdata, 16'hBBBC);
        check("rr4_a_rvalid", bus.a_rvalid, 0);

        // Lock: B granted with b_lock, then A waits while B is idle
        bus.b_lock = 1'b1;
        set_b(1, 0, 16'h0030, 16'h0);
        #1 check("lock_b_gnt", bus.b_gnt, 1);
        tick;
        set_b(0, 0, 16'h0, 16'h0);
        set_a(1, 0, 16'h0010, 16'h0);
        #1 check("lock1_a_gnt", bus.a_gnt, 0);
        check("lock1_b_rdata", bus.b_rdata, 16'hBBBB);
        tick;
        #1 check("lock2_a_gnt", bus.a_gnt, 0);
        tick;
        #1 check("lock3_a_gnt", bus.a_gnt, 0);
        check("lock3_mem_re", bus.mem_read_enable, 0);
        bus.b_lock = 1'b0;
        #1 check("unlock_a_gnt", bus.a_gnt, 1);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        #1 check("unlock_a_rdata", bus.a_rdata, 16'h1234);

        // Address wrap: write 0x1005, read 0x0005
        set_a(1, 1, 16'h1005, 16'hBEEF);
        #1 check("wrap_waddr", bus.mem_write_addr, 16'h1005);
        tick;
        set_a(1, 0, 16'h0005, 16'h0);
        #1 check("wrap_raddr", bus.mem_read_addr, 16'h0005);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        #1 check("wrap_a_rdata", bus.a_rdata, 16'hBEEF);

        // PLL drop while a read is granted: read still completes, hold restarts
        set_a(1, 0, 16'h0010, 16'h0);
        pll_lock = 1'b0;
        #1 check("pll_a_gnt", bus.a_gnt, 1);
        tick;
        pll_lock = 1'b1;
        #1 check("pll_ready", ready, 0);
        check("pll_a_rvalid", bus.a_rvalid, 1);
        check("pll_a_rdata", bus.a_rdata, 16'h1234);
        check("pll_hold_a_gnt", bus.a_gnt, 0);
        repeat (41) tick;
        #1 check("pll_hold_41", ready, 0);
        set_a(0, 0, 16'h0, 16'h0);
        tick;
        #1 check("pll_rerun", ready, 1);

        // Reset mid-read: pending response is dropped
        set_a(1, 0, 16'h0010, 16'h0);
        resetq = 1'b0;
        #1 check("rstrd_a_gnt", bus.a_gnt, 1);
        tick;
        set_a(0, 0, 16'h0, 16'h0);
        #1 check("rstrd_a_rvalid", bus.a_rvalid, 0);
        check("rstrd_ready", ready, 0);
        tick;
        resetq = 1'b1;
        tick;
        #1 check("rstrd_no_stale", bus.a_rvalid, 0);
        set_a(1, 0, 16'h0010, 16'h0);
        repeat (40) tick;
        #1 check("rstrd_hold_41", ready, 0);
        check("rstrd_hold_gnt", bus.a_gnt, 0);
        tick;
        #1 check("rstrd_ready_again", ready, 1);
        check("rstrd_a_gnt_again", bus.a_gnt, 1);
        set_a(0, 0, 16'h0, 16'h0);
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
